// File: rtl/dmem_bist_initiator.sv
// Data-port BIST initiator: writes a seeded pattern over a word range, reads it
// back and compares each word, reporting pass/fail and the first failing word.
module dmem_bist_initiator #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDRESS_BITS   = 32,
  parameter int unsigned COUNT_BITS     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic [ADDRESS_BITS-1:0]   base_address,
  input  logic [COUNT_BITS-1:0]     word_count,
  input  logic [DATA_WIDTH-1:0]     seed,
  output logic                      d_mem_read,
  output logic                      d_mem_write,
  output logic [DATA_WIDTH/8-1:0]   d_mem_byte_en,
  output logic [ADDRESS_BITS-1:0]   d_mem_address_in,
  output logic [DATA_WIDTH-1:0]     d_mem_data_in,
  input  logic [DATA_WIDTH-1:0]     d_mem_data_out,
  input  logic [ADDRESS_BITS-1:0]   d_mem_address_out,
  input  logic                      d_mem_valid,
  input  logic                      d_mem_ready,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [ADDRESS_BITS-1:0]   fail_address,
  output logic [DATA_WIDTH-1:0]     fail_data
);

  localparam int unsigned BE_W  = DATA_WIDTH / 8;
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_WAIT,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [COUNT_BITS-1:0]   idx_q, idx_d;
  logic [COUNT_BITS-1:0]   count_q, count_d;
  logic [ADDRESS_BITS-1:0] base_q, base_d;
  logic [DATA_WIDTH-1:0]   seed_q, seed_d;
  logic [TMO_W-1:0]        tmo_q, tmo_d;

  logic                    read_d, write_d, busy_d, done_d, pass_d;
  logic [BE_W-1:0]         be_d;
  logic [ADDRESS_BITS-1:0] addr_d, fail_addr_d;
  logic [DATA_WIDTH-1:0]   wdata_d, fail_data_d;

  logic [ADDRESS_BITS-1:0] start_base;
  logic [ADDRESS_BITS-1:0] cur_addr;
  logic [ADDRESS_BITS-1:0] next_addr;
  logic [COUNT_BITS-1:0]   idx_inc;
  logic                    last_word;
  logic                    accept;
  logic                    hit;
  logic                    unused_base_lsbs;

  // Expected memory contents for a given byte address
  function automatic logic [DATA_WIDTH-1:0] pat(input logic [ADDRESS_BITS-1:0] a,
                                                input logic [DATA_WIDTH-1:0]   s);
    return DATA_WIDTH'(a) ^ s;
  endfunction

  // Word addresses wrap modulo 2^ADDRESS_BITS; low two base bits are ignored
  assign start_base       = {base_address[ADDRESS_BITS-1:2], 2'b00};
  assign unused_base_lsbs = ^base_address[1:0];
  assign idx_inc          = idx_q + COUNT_BITS'(1);
  assign cur_addr         = base_q + (ADDRESS_BITS'(idx_q) << 2);
  assign next_addr        = base_q + (ADDRESS_BITS'(idx_inc) << 2);
  assign last_word        = (idx_inc == count_q);
  assign accept           = (d_mem_read | d_mem_write) & d_mem_ready;
  assign hit              = d_mem_valid && (d_mem_address_out == cur_addr);

  // State, bookkeeping and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= S_IDLE;
      idx_q            <= '0;
      count_q          <= '0;
      base_q           <= '0;
      seed_q           <= '0;
      tmo_q            <= '0;
      d_mem_read       <= 1'b0;
      d_mem_write      <= 1'b0;
      d_mem_byte_en    <= '0;
      d_mem_address_in <= '0;
      d_mem_data_in    <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      fail_address     <= '0;
      fail_data        <= '0;
    end else begin
      state_q          <= state_d;
      idx_q            <= idx_d;
      count_q          <= count_d;
      base_q           <= base_d;
      seed_q           <= seed_d;
      tmo_q            <= tmo_d;
      d_mem_read       <= read_d;
      d_mem_write      <= write_d;
      d_mem_byte_en    <= be_d;
      d_mem_address_in <= addr_d;
      d_mem_data_in    <= wdata_d;
      busy             <= busy_d;
      done             <= done_d;
      pass             <= pass_d;
      fail_address     <= fail_addr_d;
      fail_data        <= fail_data_d;
    end
  end

  // Next-state and next-output logic; request fields hold unless accepted
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    count_d     = count_q;
    base_d      = base_q;
    seed_d      = seed_q;
    tmo_d       = tmo_q;
    read_d      = d_mem_read;
    write_d     = d_mem_write;
    be_d        = d_mem_byte_en;
    addr_d      = d_mem_address_in;
    wdata_d     = d_mem_data_in;
    busy_d      = busy;
    done_d      = 1'b0;
    pass_d      = pass;
    fail_addr_d = fail_address;
    fail_data_d = fail_data;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          fail_addr_d = '0;
          fail_data_d = '0;
          if (word_count == '0) begin
            pass_d  = 1'b1;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            base_d  = start_base;
            count_d = word_count;
            seed_d  = seed;
            idx_d   = '0;
            pass_d  = 1'b0;
            busy_d  = 1'b1;
            write_d = 1'b1;
            be_d    = '1;
            addr_d  = start_base;
            wdata_d = pat(start_base, seed);
            state_d = S_WRITE;
          end
        end
      end

      S_WRITE: begin
        if (accept) begin
          if (last_word) begin
            idx_d   = '0;
            write_d = 1'b0;
            wdata_d = '0;
            read_d  = 1'b1;
            addr_d  = base_q;
            state_d = S_READ;
          end else begin
            idx_d   = idx_inc;
            addr_d  = next_addr;
            wdata_d = pat(next_addr, seed_q);
          end
        end
      end

      S_READ: begin
        if (accept) begin
          read_d  = 1'b0;
          be_d    = '0;
          tmo_d   = '0;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (hit && (d_mem_data_out == pat(cur_addr, seed_q))) begin
          if (last_word) begin
            pass_d  = 1'b1;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            addr_d  = '0;
            state_d = S_DONE;
          end else begin
            idx_d   = idx_inc;
            read_d  = 1'b1;
            be_d    = '1;
            addr_d  = next_addr;
            state_d = S_READ;
          end
        end else if (hit) begin
          // Fail fast on the first corrupted word
          fail_addr_d = cur_addr;
          fail_data_d = d_mem_data_out;
          done_d      = 1'b1;
          busy_d      = 1'b0;
          addr_d      = '0;
          state_d     = S_DONE;
        end else if (tmo_q == TMO_LAST) begin
          fail_addr_d = cur_addr;
          fail_data_d = '0;
          done_d      = 1'b1;
          busy_d      = 1'b0;
          addr_d      = '0;
          state_d     = S_DONE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dmem_bist_initiator.sv
// Directed bench for dmem_bist_initiator with a behavioural memory responder.
module tb_dmem_bist_initiator;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] base_address;
  logic [15:0] word_count;
  logic [31:0] seed;
  logic        d_mem_read;
  logic        d_mem_write;
  logic [3:0]  d_mem_byte_en;
  logic [31:0] d_mem_address_in;
  logic [31:0] d_mem_data_in;
  logic [31:0] d_mem_data_out;
  logic [31:0] d_mem_address_out;
  logic        d_mem_valid;
  logic        d_mem_ready;
  logic        busy;
  logic        done;
  logic        pass;
  logic [31:0] fail_address;
  logic [31:0] fail_data;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Memory model state and knobs
  logic [31:0] mem [logic [31:0]];
  logic [31:0] wr_a[$];
  logic [31:0] wr_d[$];
  logic [31:0] rd_a[$];
  int          resp_delay    = 1;
  bit          drop_resp     = 1'b0;
  bit          corrupt_en    = 1'b0;
  logic [31:0] corrupt_addr  = 32'h0;
  bit          stray_en      = 1'b0;
  int          stall_wr_at   = -1;
  int          stall_rd_at   = -1;
  int          wr_stall_left = 0;
  int          rd_stall_left = 0;
  bit          resp_pending  = 1'b0;
  int          resp_cnt      = 0;
  logic [31:0] resp_addr     = 32'h0;
  bit          stall_prev    = 1'b0;
  bit          prev_wr       = 1'b0;
  bit          prev_rd       = 1'b0;
  logic [31:0] prev_addr     = 32'h0;
  logic [31:0] prev_data     = 32'h0;

  int          restart_at = 0;
  int          t_start    = 0;
  int          t_done     = 0;
  bit          got_done;
  logic [31:0] exp_a[4];
  logic [31:0] exp_d[4];

  dmem_bist_initiator dut (
    .clock             (clock),
    .reset             (reset),
    .start             (start),
    .base_address      (base_address),
    .word_count        (word_count),
    .seed              (seed),
    .d_mem_read        (d_mem_read),
    .d_mem_write       (d_mem_write),
    .d_mem_byte_en     (d_mem_byte_en),
    .d_mem_address_in  (d_mem_address_in),
    .d_mem_data_in     (d_mem_data_in),
    .d_mem_data_out    (d_mem_data_out),
    .d_mem_address_out (d_mem_address_out),
    .d_mem_valid       (d_mem_valid),
    .d_mem_ready       (d_mem_ready),
    .busy              (busy),
    .done              (done),
    .pass              (pass),
    .fail_address      (fail_address),
    .fail_data         (fail_data)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_logs(input int nw, input int nr);
    check("wr_count", 64'(wr_a.size()), 64'(nw));
    for (int i = 0; i < nw && i < wr_a.size(); i++) begin
      check($sformatf("wr_addr[%0d]", i), 64'(wr_a[i]), 64'(exp_a[i]));
      check($sformatf("wr_data[%0d]", i), 64'(wr_d[i]), 64'(exp_d[i]));
    end
    check("rd_count", 64'(rd_a.size()), 64'(nr));
    for (int i = 0; i < nr && i < rd_a.size(); i++)
      check($sformatf("rd_addr[%0d]", i), 64'(rd_a[i]), 64'(exp_a[i]));
  endtask

  // Pulse start, wait (bounded) for done, verify the pulse is one cycle long
  task automatic run_bist(input logic [31:0] b, input logic [15:0] n,
                          input logic [31:0] s, input int limit);
    wr_a.delete();
    wr_d.delete();
    rd_a.delete();
    @(negedge clock);
    base_address = b;
    word_count   = n;
    seed         = s;
    start        = 1'b1;
    t_start      = cyc;
    got_done     = 1'b0;
    for (int k = 1; k <= limit && !got_done; k++) begin
      @(negedge clock);
      start      = (restart_at != 0) && (k == restart_at);
      word_count = start ? 16'd0 : n;
      if (done) begin
        got_done = 1'b1;
        t_done   = cyc;
      end
    end
    start      = 1'b0;
    restart_at = 0;
    check("done_seen", 64'(got_done), 64'd1);
    if (got_done) begin
      check("busy_at_done", 64'(busy), 64'd0);
      @(negedge clock);
      check("done_pulse_len", 64'(done), 64'd0);
      check("busy_after_done", 64'(busy), 64'd0);
    end
  endtask

  // Memory responder: drives ready/response at negedges, logs accepted requests
  initial begin : mem_model
    d_mem_valid       = 1'b0;
    d_mem_ready       = 1'b1;
    d_mem_address_out = 32'h0;
    d_mem_data_out    = 32'h0;
    forever begin
      @(negedge clock);
      d_mem_valid = 1'b0;
      if (resp_pending) begin
        if (resp_cnt <= 1) begin
          resp_pending = 1'b0;
          if (!drop_resp) begin
            d_mem_valid       = 1'b1;
            d_mem_address_out = resp_addr;
            d_mem_data_out    = mem.exists(resp_addr) ? mem[resp_addr] : 32'h0;
            if (corrupt_en && resp_addr == corrupt_addr)
              d_mem_data_out[0] = ~d_mem_data_out[0];
          end
        end else begin
          resp_cnt--;
        end
      end

      d_mem_ready = 1'b1;
      if (d_mem_write && wr_a.size() == stall_wr_at && wr_stall_left > 0) begin
        d_mem_ready = 1'b0;
        wr_stall_left--;
      end
      if (d_mem_read && rd_a.size() == stall_rd_at && rd_stall_left > 0) begin
        d_mem_ready = 1'b0;
        rd_stall_left--;
      end

      if (stall_prev) begin
        check("stall_kind", 64'({d_mem_write, d_mem_read}), 64'({prev_wr, prev_rd}));
        check("stall_addr", 64'(d_mem_address_in), 64'(prev_addr));
        if (prev_wr) check("stall_data", 64'(d_mem_data_in), 64'(prev_data));
      end
      stall_prev = (d_mem_write || d_mem_read) && !d_mem_ready;
      prev_wr    = d_mem_write;
      prev_rd    = d_mem_read;
      prev_addr  = d_mem_address_in;
      prev_data  = d_mem_data_in;

      if ((d_mem_write || d_mem_read) && d_mem_ready) begin
        check("byte_en", 64'(d_mem_byte_en), 64'hF);
        check("rw_excl", 64'(d_mem_write & d_mem_read), 64'd0);
        if (d_mem_write) begin
          wr_a.push_back(d_mem_address_in);
          wr_d.push_back(d_mem_data_in);
          mem[d_mem_address_in] = d_mem_data_in;
        end else begin
          rd_a.push_back(d_mem_address_in);
          resp_pending = 1'b1;
          resp_cnt     = resp_delay;
          resp_addr    = d_mem_address_in;
        end
      end

      if (stray_en && d_mem_write) begin
        d_mem_valid       = 1'b1;
        d_mem_address_out = d_mem_address_in;
        d_mem_data_out    = 32'hDEADBEEF;
        stray_en          = 1'b0;
      end
    end
  end

  initial begin : main
    reset        = 1'b1;
    start        = 1'b0;
    base_address = 32'h0;
    word_count   = 16'h0;
    seed         = 32'h0;
    repeat (3) @(negedge clock);
    check("rst_ctrl", 64'({d_mem_read, d_mem_write, d_mem_byte_en, busy, done, pass}), 64'd0);
    check("rst_addr", 64'(d_mem_address_in), 64'd0);
    check("rst_wdata", 64'(d_mem_data_in), 64'd0);
    check("rst_fail_addr", 64'(fail_address), 64'd0);
    check("rst_fail_data", 64'(fail_data), 64'd0);
    reset = 1'b0;

    // Nominal run with a stray valid injected during the write phase
    exp_a = '{32'h0000_0100, 32'h0000_0104, 32'h0000_0108, 32'h0000_010C};
    exp_d = '{32'hA5A5_A4A5, 32'hA5A5_A4A1, 32'hA5A5_A4AD, 32'hA5A5_A4A9};
    stray_en = 1'b1;
    run_bist(32'h100, 16'd4, 32'hA5A5_A5A5, 100);
    check("nom_latency", 64'(t_done - t_start), 64'd13);
    check("nom_pass", 64'(pass), 64'd1);
    check("nom_fail_addr", 64'(fail_address), 64'd0);
    check_logs(4, 4);

    // Backpressure on 2nd write and 3rd read, ignored restart, unaligned base
    stall_wr_at   = 1;
    wr_stall_left = 3;
    stall_rd_at   = 2;
    rd_stall_left = 3;
    restart_at    = 3;
    run_bist(32'h103, 16'd4, 32'hA5A5_A5A5, 100);
    stall_wr_at = -1;
    stall_rd_at = -1;
    check("bp_latency", 64'(t_done - t_start), 64'd19);
    check("bp_pass", 64'(pass), 64'd1);
    check_logs(4, 4);

    // Corrupted word at 0x108: fail fast, no read of 0x10C
    corrupt_en   = 1'b1;
    corrupt_addr = 32'h108;
    run_bist(32'h100, 16'd4, 32'hA5A5_A5A5, 100);
    corrupt_en = 1'b0;
    check("cor_latency", 64'(t_done - t_start), 64'd11);
    check("cor_pass", 64'(pass), 64'd0);
    check("cor_fail_addr", 64'(fail_address), 64'h108);
    check("cor_fail_data", 64'(fail_data), 64'hA5A5_A4AC);
    check_logs(4, 3);

    // Reset while idle clears the held result
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("idle_rst_fail_addr", 64'(fail_address), 64'd0);
    check("idle_rst_fail_data", 64'(fail_data), 64'd0);
    reset = 1'b0;

    // Response delayed 1000 cycles still passes
    resp_delay = 1000;
    run_bist(32'h200, 16'd1, 32'h0, 3000);
    resp_delay = 1;
    check("dly_latency", 64'(t_done - t_start), 64'd1003);
    check("dly_pass", 64'(pass), 64'd1);

    // Dropped response times out after 1024 wait cycles
    drop_resp = 1'b1;
    run_bist(32'h200, 16'd1, 32'h0, 3000);
    drop_resp = 1'b0;
    check("tmo_latency", 64'(t_done - t_start), 64'd1027);
    check("tmo_pass", 64'(pass), 64'd0);
    check("tmo_fail_addr", 64'(fail_address), 64'h200);
    check("tmo_fail_data", 64'(fail_data), 64'd0);

    // Zero-length test completes immediately with no memory traffic
    run_bist(32'h300, 16'd0, 32'h0, 10);
    check("zero_latency", 64'(t_done - t_start), 64'd1);
    check("zero_pass", 64'(pass), 64'd1);
    check_logs(0, 0);

    // Address range wrapping past the top of the address space
    exp_a = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0};
    exp_d = '{32'hEDCB_A980, 32'hEDCB_A984, 32'h1234_5678, 32'h0};
    run_bist(32'hFFFF_FFF8, 16'd3, 32'h1234_5678, 100);
    check("wrap_latency", 64'(t_done - t_start), 64'd10);
    check("wrap_pass", 64'(pass), 64'd1);
    check_logs(3, 3);

    // Reset while waiting on a read response
    drop_resp = 1'b1;
    wr_a.delete();
    wr_d.delete();
    rd_a.delete();
    @(negedge clock);
    base_address = 32'h400;
    word_count   = 16'd2;
    seed         = 32'h0;
    start        = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (20) @(negedge clock);
    check("wait_busy", 64'(busy), 64'd1);
    check("wait_rd_count", 64'(rd_a.size()), 64'd1);
    check("wait_addr", 64'(d_mem_address_in), 64'h400);
    reset = 1'b1;
    @(negedge clock);
    check("mid_rst_ctrl", 64'({d_mem_read, d_mem_write, d_mem_byte_en, busy, done, pass}), 64'd0);
    check("mid_rst_addr", 64'(d_mem_address_in), 64'd0);
    check("mid_rst_wdata", 64'(d_mem_data_in), 64'd0);
    check("mid_rst_fail_addr", 64'(fail_address), 64'd0);
    check("mid_rst_fail_data", 64'(fail_data), 64'd0);
    reset     = 1'b0;
    drop_resp = 1'b0;
    repeat (3) @(negedge clock);
    check("post_rst_idle", 64'({d_mem_read, d_mem_write, busy, done}), 64'd0);

    // Recovery after the mid-test reset
    exp_a = '{32'h0000_0400, 32'h0, 32'h0, 32'h0};
    exp_d = '{32'h0000_0400, 32'h0, 32'h0, 32'h0};
    run_bist(32'h400, 16'd1, 32'h0, 100);
    check("rec_latency", 64'(t_done - t_start), 64'd4);
    check("rec_pass", 64'(pass), 64'd1);
    check_logs(1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_bist_initiator.md
Name: dmem_bist_initiator

Overview:
- Built-in self-test initiator for the data port of the dual-port BRAM memory subsystem.
- Writes a seeded pattern over a word range, then reads each word back and compares it against the pattern.
- Reports pass/fail and the first failing address and data.
- Muxed in place of the core's d_mem port during bring-up. Tolerates scan-induced response latency up to TIMEOUT_CYCLES.

Parameters:
- DATA_WIDTH, 32, data bus width (bits).
- ADDRESS_BITS, 32, byte address width.
- COUNT_BITS, 16, width of word_count.
- TIMEOUT_CYCLES, 1024, maximum cycles to wait for d_mem_valid per read.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; sampled only in IDLE.
- base_address  input  ADDRESS_BITS  first byte address; bits [1:0] treated as 0.
- word_count  input  COUNT_BITS  number of words to test.
- seed  input  DATA_WIDTH  pattern seed.
- d_mem_read  output  1  read request.
- d_mem_write  output  1  write request.
- d_mem_byte_en  output  DATA_WIDTH/8  byte enables; all ones during a request.
- d_mem_address_in  output  ADDRESS_BITS  request address.
- d_mem_data_in  output  DATA_WIDTH  write data.
- d_mem_data_out  input  DATA_WIDTH  read response data.
- d_mem_address_out  input  ADDRESS_BITS  address tag of the response.
- d_mem_valid  input  1  response valid.
- d_mem_ready  input  1  memory can accept a request this cycle.
- busy  output  1  high from start acceptance until done.
- done  output  1  one-cycle pulse at test end.
- pass  output  1  result; held until the next start.
- fail_address  output  ADDRESS_BITS  first failing address; held.
- fail_data  output  DATA_WIDTH  data observed at the failure; 0 on timeout.

Behaviour:
- Reset behaviour: state IDLE; all outputs 0. This applies when reset is asserted at any time, including mid-test; no request is left asserted afterwards.
- Pattern: pat(a) = a XOR seed, with a zero-extended or truncated to DATA_WIDTH.
- Addressing: a_i = base + 4*i, modulo 2^ADDRESS_BITS, so the range wraps silently.
- A request is accepted in a cycle when (d_mem_read or d_mem_write) is high and d_mem_ready is high.
- Address, data and byte enable are held stable while a request is asserted but not yet accepted.
- Only one of read/write is high at a time.
- IDLE:
  - start with word_count=0 -> DONE directly with pass=1.
  - start with word_count>0 -> latch base, count and seed; clear pass and fail_*; busy=1; go to WRITE.
  - start while busy is ignored.
- WRITE:
  - Drive d_mem_write=1 with a_i and pat(a_i).
  - On acceptance, i++ and the next request appears the following cycle. Back-to-back acceptance gives 1 write per cycle.
  - After the last acceptance: i=0, go to READ.
  - Writes produce no response. Any d_mem_valid seen in this state is ignored.
- READ:
  - Drive d_mem_read=1 with a_i.
  - On acceptance, drop the request next cycle, clear the timeout counter, go to WAIT.
- WAIT:
  - Match condition: d_mem_valid=1 and d_mem_address_out==a_i.
  - Match with data==pat(a_i): i++. Go to READ, or to DONE after the last word.
  - Match with data!=pat(a_i): fail_address=a_i, fail_data=data, go to DONE with pass=0 (fail-fast).
  - d_mem_valid with a non-matching address is ignored and keeps counting toward the timeout.
  - Timeout counter reaches TIMEOUT_CYCLES-1 with no match: fail_address=a_i, fail_data=0, go to DONE with pass=0.
  - A valid arriving in the same cycle as the timeout wins.
- DONE: done=1 for exactly one cycle, busy=0, return to IDLE. pass and fail_* are held.
- Latency: minimum per word with 1-cycle memory read latency is 1 write cycle + 2 read cycles.
- Width rules: word_count width is COUNT_BITS, and i is COUNT_BITS wide. The timeout counter is clog2(TIMEOUT_CYCLES)+1 bits wide.

Test Plan:
- Nominal:
  - Stimulus: base=0x100, count=4, seed=0xA5A5A5A5, ideal memory (ready=1, read valid 1 cycle after acceptance).
  - Required: writes to 0x100..0x10C with data 0xA5A5A4A5..0xA5A5A4A9; 4 verified reads; done pulse with pass=1; busy low after done.
- Backpressure:
  - Stimulus: hold ready=0 for 3 cycles on the 2nd write and the 3rd read.
  - Required: address and data stable throughout the stall; no duplicate or skipped address; pass=1.
- Corruption:
  - Stimulus: memory model flips bit 0 at address 0x108.
  - Required: done with pass=0, fail_address=0x108, fail_data=0xA5A5A4AC; no read issued to 0x10C.
- Scan delay and timeout:
  - Delay of 1000 cycles with TIMEOUT_CYCLES=1024 -> pass=1.
  - Dropped response -> fail after 1024 wait cycles, fail_data=0.
- Edge cases:
  - count=0 -> done one cycle after start, pass=1, no d_mem request.
  - base=0xFFFFFFF8, count=3 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- Reset and start handling:
  - Reset asserted while in WAIT -> next cycle all outputs 0, state IDLE.
  - A start pulse during busy is ignored.
  - A stray valid during WRITE is ignored.
